// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the stack operation sequencer.
// Holds the FSM state encoding, the decode-stage req_kind encodings, the
// internal sequence kind, and the default stack-pointer / drain parameters.
package stack_op_sequencer_pkg;

  localparam logic [31:0] SP_INIT_DEFAULT      = 32'h0000_07FF;
  localparam int          DRAIN_CYCLES_DEFAULT = 4;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    POP_FL,
    POP_LO,
    POP_HI,
    LOAD
  } state_t;

  typedef enum logic [1:0] {
    KIND_CALL = 2'b00,
    KIND_RET  = 2'b01,
    KIND_RETI = 2'b10,
    KIND_RSVD = 2'b11
  } req_kind_t;

  // Which sequence is in flight; decides the branch after PUSH_LO and
  // whether LOAD also restores flags.
  typedef enum logic [1:0] {
    SEQ_CALL,
    SEQ_RET,
    SEQ_RETI,
    SEQ_INT
  } seq_t;

  function automatic logic is_push(input state_t s);
    return (s == PUSH_HI) || (s == PUSH_LO) || (s == PUSH_FL);
  endfunction

  function automatic logic is_pop(input state_t s);
    return (s == POP_FL) || (s == POP_LO) || (s == POP_HI);
  endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Request handshake and stack-memory bus of the sequencer.
//   req_valid/req_kind/req_ready : decode-stage request handshake
//   mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rdata : stack memory port
// master = the sequencer; slave = its environment (decode stage + memory).
interface stack_op_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic        req_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic [15:0] mem_rdata;

  modport master (
    input  req_valid, req_kind, mem_gnt, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_kind, mem_gnt, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_op_sequencer_sp.sv
// Stack pointer unit: owns sp, applies decrement on a granted push and
// increment on a granted pop (32-bit wrap), and pulses stack_err for one
// cycle after a push granted at sp==0 or a pop granted at sp==SP_INIT.
//   clk, reset      : clock, synchronous active-high reset
//   push_done       : a push completed this cycle
//   pop_done        : a pop completed this cycle
//   sp              : current stack pointer
//   stack_err       : overflow/underflow pulse
module stack_pointer_unit #(
  parameter logic [31:0] SP_INIT = 32'h0000_07FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_done,
  input  logic        pop_done,
  output logic [31:0] sp,
  output logic        stack_err
);

  logic [31:0] sp_reg;
  logic        err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg  <= SP_INIT;
      err_reg <= 1'b0;
    end else begin
      err_reg <= (push_done && (sp_reg == 32'd0)) ||
                 (pop_done && (sp_reg == SP_INIT));
      // The access still completes on error; sp simply wraps.
      if (push_done)
        sp_reg <= sp_reg - 32'd1;
      else if (pop_done)
        sp_reg <= sp_reg + 32'd1;
    end
  end

  assign sp        = sp_reg;
  assign stack_err = err_reg;

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: runs CALL / RET / RETI and interrupt-entry
// stack sequences against a 16-bit stack memory, then loads the new PC.
//   clk, reset        : clock, synchronous active-high reset
//   bus               : request handshake + stack memory port (master side)
//   intr              : interrupt request pulse
//   pc, target, flags : return PC, CALL target, flags (sampled on accept)
//   int_vector        : interrupt handler address
//   stall_fetch       : freeze fetch while a sequence runs
//   pc_load(_value)   : one-cycle PC load
//   flags_load(_value): one-cycle flag restore (RETI)
//   sp, stack_err     : stack pointer and overflow/underflow pulse
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter logic [31:0] SP_INIT      = SP_INIT_DEFAULT,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_op_sequencer_if.master  bus,
  input  logic                  intr,
  input  logic [31:0]           pc,
  input  logic [31:0]           target,
  input  logic [31:0]           int_vector,
  input  logic [2:0]            flags,
  output logic                  stall_fetch,
  output logic                  pc_load,
  output logic [31:0]           pc_load_value,
  output logic                  flags_load,
  output logic [2:0]            flags_load_value,
  output logic [31:0]           sp,
  output logic                  stack_err
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t      state_reg, state_next;
  seq_t        seq_reg, seq_next;
  logic        pending_reg, pending_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0] pc_lat_reg, pc_lat_next;
  logic [31:0] tgt_reg, tgt_next;     // value LOAD will put on pc_load_value
  logic [2:0]  fl_reg, fl_next;
  logic [15:0] lo_reg, lo_next;

  logic        req_ready_reg, mem_req_reg, mem_we_reg, stall_reg;
  logic [15:0] mem_wdata_reg;
  logic        pc_load_reg, flags_load_reg;
  logic [31:0] pc_load_value_reg;
  logic [2:0]  flags_load_value_reg;

  logic granted, accept;

  assign granted = mem_req_reg && bus.mem_gnt;
  assign accept  = req_ready_reg && bus.req_valid && (bus.req_kind != KIND_RSVD);

  always_comb begin
    state_next = state_reg;
    seq_next   = seq_reg;
    cnt_next   = cnt_reg;
    pc_lat_next = pc_lat_reg;
    tgt_next   = tgt_reg;
    fl_next    = fl_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = DRAIN;
          seq_next   = SEQ_INT;
          cnt_next   = '0;
        end else if (accept) begin
          pc_lat_next = pc;
          tgt_next    = target;
          fl_next     = flags;
          case (bus.req_kind)
            KIND_CALL: begin state_next = PUSH_HI; seq_next = SEQ_CALL; end
            KIND_RET:  begin state_next = POP_LO;  seq_next = SEQ_RET;  end
            default:   begin state_next = POP_FL;  seq_next = SEQ_RETI; end
          endcase
        end
      end
      DRAIN: begin
        if (cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
          state_next  = PUSH_HI;
          pc_lat_next = pc;
          fl_next     = flags;
          tgt_next    = int_vector;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PUSH_HI: if (granted) state_next = PUSH_LO;
      PUSH_LO: if (granted) state_next = (seq_reg == SEQ_INT) ? PUSH_FL : LOAD;
      PUSH_FL: if (granted) state_next = LOAD;
      POP_FL: if (granted) begin
        fl_next    = bus.mem_rdata[2:0];
        state_next = POP_LO;
      end
      POP_LO: if (granted) begin
        lo_next    = bus.mem_rdata;
        state_next = POP_HI;
      end
      POP_HI: if (granted) begin
        tgt_next   = {bus.mem_rdata, lo_reg};
        state_next = LOAD;
      end
      default: state_next = IDLE;   // LOAD and any illegal encoding
    endcase
    // A new pulse wins over the clear on DRAIN entry so it is not lost.
    pending_next = intr || (pending_reg && !(state_reg == IDLE && state_next == DRAIN));
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= IDLE;
      seq_reg              <= SEQ_CALL;
      pending_reg          <= 1'b0;
      cnt_reg              <= '0;
      pc_lat_reg           <= '0;
      tgt_reg              <= '0;
      fl_reg               <= '0;
      lo_reg               <= '0;
      req_ready_reg        <= 1'b1;
      mem_req_reg          <= 1'b0;
      mem_we_reg           <= 1'b0;
      mem_wdata_reg        <= '0;
      stall_reg            <= 1'b0;
      pc_load_reg          <= 1'b0;
      pc_load_value_reg    <= '0;
      flags_load_reg       <= 1'b0;
      flags_load_value_reg <= '0;
    end else begin
      state_reg     <= state_next;
      seq_reg       <= seq_next;
      pending_reg   <= pending_next;
      cnt_reg       <= cnt_next;
      pc_lat_reg    <= pc_lat_next;
      tgt_reg       <= tgt_next;
      fl_reg        <= fl_next;
      lo_reg        <= lo_next;
      req_ready_reg <= (state_next == IDLE) && !pending_next;
      mem_req_reg   <= is_push(state_next) || is_pop(state_next);
      mem_we_reg    <= is_push(state_next);
      case (state_next)
        PUSH_HI: mem_wdata_reg <= pc_lat_next[31:16];
        PUSH_LO: mem_wdata_reg <= pc_lat_next[15:0];
        PUSH_FL: mem_wdata_reg <= {13'b0, fl_next};
        default: mem_wdata_reg <= '0;
      endcase
      stall_reg            <= (state_next != IDLE);
      pc_load_reg          <= (state_next == LOAD);
      pc_load_value_reg    <= (state_next == LOAD) ? tgt_next : 32'd0;
      flags_load_reg       <= (state_next == LOAD) && (seq_next == SEQ_RETI);
      flags_load_value_reg <= ((state_next == LOAD) && (seq_next == SEQ_RETI)) ? fl_next : 3'd0;
    end
  end

  stack_pointer_unit #(.SP_INIT(SP_INIT)) u_sp (
    .clk       (clk),
    .reset     (reset),
    .push_done (granted && mem_we_reg),
    .pop_done  (granted && !mem_we_reg),
    .sp        (sp),
    .stack_err (stack_err)
  );

  assign bus.req_ready = req_ready_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  // Pushes write at sp, pops read the word just above it.
  assign bus.mem_addr  = mem_req_reg ? (mem_we_reg ? sp : sp + 32'd1) : 32'd0;

  assign stall_fetch      = stall_reg;
  assign pc_load          = pc_load_reg;
  assign pc_load_value    = pc_load_value_reg;
  assign flags_load       = flags_load_reg;
  assign flags_load_value = flags_load_value_reg;

endmodule
